imem_port_arbiter: RTL
======================

# imem_port_arbiter

Sequences and shares the single-port, synchronous-read instruction memory between the core's fetch path and a boot/patch loader port. After reset it holds the core in reset while the loader fills memory. It then releases the core and arbitrates fetch against loader writes, using a starvation counter so neither side stalls forever. It sits between the fetch stage, the loader, and the instruction memory array.

## Interface
Parameters:
- DEPTH, 256: memory size in 32-bit words (power of two); AW = $clog2(DEPTH)
- STARVE_MAX, 8: consecutive denied loader cycles before the loader is forced a grant
- BOOT_SKIP, 0: 1 = start in RUN after reset (no load phase)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_req  in  1  core requests an instruction
- fetch_addr  in  32  byte address
- fetch_instr  out  32  returned instruction
- fetch_valid  out  1  fetch_instr valid this cycle
- fetch_stall  out  1  request not granted this cycle
- fetch_err  out  1  with fetch_valid: misaligned or out-of-range
- ld_valid  in  1  loader write request
- ld_ready  out  1  loader write accepted when ld_valid && ld_ready
- ld_addr  in  32  byte address of the write
- ld_data  in  32  write data
- ld_done  in  1  loader finished (level, sampled in LOAD)
- core_rst  out  1  holds the core in reset
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, one cycle after mem_en && !mem_we

## Operation
- Reset values:
  - state = LOAD, or RUN if BOOT_SKIP
  - core_rst = 1 (0 if BOOT_SKIP)
  - fetch_valid, fetch_err, fetch_stall, mem_en, mem_we = 0
  - fetch_instr = 32'h00000013
  - starvation counter = 0
- LOAD:
  - ld_ready = 1; fetch ignored, fetch_stall = fetch_req.
  - On ld_done, go to DRAIN. A write in the same cycle is still performed.
- DRAIN: one cycle; ld_ready = 0; core_rst = 1; go to RUN.
- RUN: core_rst = 0. Grant rules, in priority order:
  - Starvation counter == STARVE_MAX and ld_valid: loader granted, fetch_stall = fetch_req, counter cleared.
  - Else fetch_req: fetch granted; ld_ready = 0; if ld_valid, counter increments (saturating at STARVE_MAX).
  - Else ld_valid: loader granted, counter cleared.
  - Counter clears whenever ld_valid = 0.
- Address rules:
  - mem_addr = addr[AW+1:2].
  - Out of range means addr >= 4*DEPTH.
  - Misaligned means addr[1:0] != 0.
- Bad fetch:
  - No memory access.
  - Next cycle: fetch_valid = 1, fetch_err = 1, fetch_instr = 32'h00000013 (NOP).
- Bad loader write: accepted (ld_ready as normal) but mem_we suppressed.
- Loader writes in RUN never drop; each is granted within STARVE_MAX+1 cycles.
- rst in any state, including mid-load or mid-fetch:
  - Next state is LOAD (or RUN if BOOT_SKIP); all outputs return to reset values.
  - A pending fetch_valid is cancelled.

## Timing
- Fetch latency is 1 cycle: grant in cycle N gives fetch_valid in N+1, with fetch_instr = mem_rdata.
- fetch_stall, ld_ready, mem_en, mem_we and mem_addr are combinational from the state, the counter and the requests.
- ld_done sampled in cycle N: DRAIN in N+1, RUN with core_rst = 0 in N+2.
- Write then fetch of the same address in consecutive cycles returns the new data (memory is write-first).
- Maximum fetch stall is one cycle per STARVE_MAX+1 cycles under continuous ld_valid.

## Structure
- Package imem_arb_pkg:
  - typedef enum logic [1:0] {LOAD, DRAIN, RUN} arb_state_t
  - localparam NOP_INSTR = 32'h00000013
- Sub-module imem_starve_cnt:
  - Saturating counter with inc/clr inputs and an at_max output, parameterised by STARVE_MAX.
- The memory array itself stays external.

## Test plan
- Load words 0x00500093, 0x00A00113 at addresses 0x0 and 0x4, then assert ld_done -> core_rst falls exactly 2 cycles later; fetch 0x4 -> fetch_valid next cycle with 0x00A00113.
- In RUN, fetch_req held high and ld_valid high with STARVE_MAX = 8:
  - 8 cycles show fetch granted and ld_ready = 0.
  - 9th cycle: loader granted, fetch_stall = 1.
  - Next cycle: fetch granted again.
- fetch_addr = 0x00000006 -> no mem_en; next cycle fetch_valid = 1, fetch_err = 1, fetch_instr = 0x00000013. Same for fetch_addr = 0x00000400 with DEPTH = 256.
- Loader write to 0x00000400 in LOAD -> ld_ready = 1, mem_we = 0, no memory change.
- rst asserted mid-load, and again the cycle after a fetch grant:
  - Next cycle: state LOAD, core_rst = 1, fetch_valid = 0, counter cleared.
- BOOT_SKIP = 1: after rst, core_rst = 0 immediately and the fetch of 0x0 completes in 1 cycle.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types, constants and address checks for the instruction-memory
// port arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    RUN
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // True when a byte address is word aligned and inside a DEPTH-word array.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] limit;
    limit = 34'(depth) << 2;
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating count of consecutive cycles the loader was denied the memory.
module imem_starve_cnt
  import imem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] count;

  // Clear has priority so a forced loader grant restarts the window.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != CW'(STARVE_MAX))) begin
      count <= count + CW'(1);
    end
  end

  assign at_max = (count == CW'(STARVE_MAX));

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a single-port synchronous-read instruction memory between the core
// fetch path and a boot/patch loader, holding the core in reset while loading.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned BOOT_SKIP  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_req,
  input  logic [31:0]                fetch_addr,
  output logic [31:0]                fetch_instr,
  output logic                       fetch_valid,
  output logic                       fetch_stall,
  output logic                       fetch_err,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [31:0]                ld_addr,
  input  logic [31:0]                ld_data,
  input  logic                       ld_done,
  output logic                       core_rst,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam arb_state_t RST_STATE = (BOOT_SKIP != 0) ? RUN : LOAD;

  arb_state_t state, state_nxt;
  logic       rsp_valid, rsp_err;
  logic       rsp_valid_nxt, rsp_err_nxt;
  logic       cnt_inc, cnt_clr, at_max;
  logic       fetch_ok, ld_ok;

  assign fetch_ok = addr_ok(fetch_addr, DEPTH);
  assign ld_ok    = addr_ok(ld_addr, DEPTH);

  imem_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .at_max(at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

  // While rst is high every combinational output is held at its reset value,
  // so nothing reaches the memory from a state that is about to be discarded.
  always_comb begin
    state_nxt     = state;
    ld_ready      = 1'b0;
    fetch_stall   = 1'b0;
    core_rst      = 1'b1;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = ld_addr[AW+1:2];
    mem_wdata     = ld_data;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    cnt_inc       = 1'b0;
    cnt_clr       = 1'b1;

    if (rst) begin
      core_rst = (BOOT_SKIP == 0);
    end else begin
      case (state)
        LOAD: begin
          ld_ready    = 1'b1;
          fetch_stall = fetch_req;
          mem_en      = ld_valid && ld_ok;
          mem_we      = ld_valid && ld_ok;
          if (ld_done) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          fetch_stall = fetch_req;
          state_nxt   = RUN;
        end
        RUN: begin
          core_rst = 1'b0;
          if (at_max && ld_valid) begin
            ld_ready    = 1'b1;
            fetch_stall = fetch_req;
            mem_en      = ld_ok;
            mem_we      = ld_ok;
          end else if (fetch_req) begin
            mem_en        = fetch_ok;
            mem_addr      = fetch_addr[AW+1:2];
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = !fetch_ok;
            cnt_inc       = ld_valid;
            cnt_clr       = !ld_valid;
          end else if (ld_valid) begin
            ld_ready = 1'b1;
            mem_en   = ld_ok;
            mem_we   = ld_ok;
          end
        end
        default: begin
          state_nxt = RST_STATE;
        end
      endcase
    end
  end

  assign fetch_valid = rsp_valid;
  assign fetch_err   = rsp_err;
  assign fetch_instr = (rsp_valid && !rsp_err) ? mem_rdata : NOP_INSTR;

endmodule
